// File: rtl/uart_tx_cfg_pkg.sv
// rtl/uart_tx_cfg_pkg.sv - shared types, codes and helpers for the configurable UART transmitter
package uart_tx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    // Out-of-range word lengths fall back to the widest supported word.
    function automatic logic [3:0] clamp_dbits(input logic [3:0] cfg, input int unsigned dbit_max);
        if (cfg >= 4'd5 && 32'(cfg) <= dbit_max) begin
            return cfg;
        end
        return 4'(dbit_max);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - ready/valid word handshake between the TX FIFO and the transmitter
interface uart_tx_cfg_if #(
    parameter int DBIT_MAX = 9
);
    logic [DBIT_MAX-1:0] din;
    logic                din_valid;
    logic                din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - UART transmitter with per-frame word length, parity and stop configuration
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter int DBIT_MAX   = 9,
    parameter int OVERSAMPLE = 16
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_cfg_if.slave        in_if,
    input  logic                s_tick_i,
    input  logic [3:0]          cfg_dbits_i,
    input  logic [1:0]          cfg_parity_i,
    input  logic [1:0]          cfg_stop_i,
    input  logic                tx_break_i,
    output logic                busy_o,
    output logic                tx_done_tick_o,
    output logic                tx_o
);

    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam int BW = $clog2(DBIT_MAX + 1);

    localparam logic [TW-1:0] TICK_BIT = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_1P5 = TW'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_2   = TW'(2 * OVERSAMPLE - 1);

    state_e              state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [BW-1:0]       last_bit_q, last_bit_d;
    logic [DBIT_MAX-1:0] shift_q, shift_d;
    logic [1:0]          par_mode_q, par_mode_d;
    logic [1:0]          stop_q, stop_d;
    logic                par_bit_q, par_bit_d;
    logic                tx_q, tx_d;
    logic                rdy_en_q;

    logic                din_ready;
    logic                accept;
    logic [3:0]          dbits_clamped;
    logic                par_calc;
    logic                par_en;
    logic [TW-1:0]       stop_last;
    logic                bit_end;
    logic                stop_end;

    assign dbits_clamped = clamp_dbits(cfg_dbits_i, DBIT_MAX);
    assign accept        = in_if.din_valid && din_ready;
    assign par_en        = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
    assign bit_end       = s_tick_i && (tick_q == TICK_BIT);
    assign stop_end      = s_tick_i && (tick_q == stop_last);

    always_comb begin
        case (stop_q)
            STOP_1:   stop_last = TICK_BIT;
            STOP_1P5: stop_last = TICK_1P5;
            STOP_2:   stop_last = TICK_2;
            default:  stop_last = TICK_BIT;
        endcase
    end

    // Parity is taken over the clamped word at accept time, so only bits actually sent count.
    always_comb begin
        par_calc = 1'b0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            if (i < int'(dbits_clamped)) begin
                par_calc = par_calc ^ in_if.din[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept)   state_d = ST_START;
            ST_START:  if (bit_end)  state_d = ST_DATA;
            ST_DATA:   if (bit_end && bit_q == last_bit_q) state_d = par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end)  state_d = ST_STOP;
            ST_STOP:   if (stop_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_d     = tick_q;
        bit_d      = bit_q;
        last_bit_d = last_bit_q;
        shift_d    = shift_q;
        par_mode_d = par_mode_q;
        stop_d     = stop_q;
        par_bit_d  = par_bit_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                shift_d    = in_if.din;
                last_bit_d = BW'(dbits_clamped - 4'd1);
                par_mode_d = cfg_parity_i;
                stop_d     = cfg_stop_i;
                par_bit_d  = par_calc ^ (cfg_parity_i == PAR_ODD);
                tick_d     = '0;
                bit_d      = '0;
            end
        end else if (s_tick_i) begin
            if ((state_q == ST_STOP) ? stop_end : bit_end) begin
                tick_d = '0;
            end else begin
                tick_d = tick_q + 1'b1;
            end
            if (state_q == ST_DATA && bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = (bit_q == last_bit_q) ? '0 : bit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q     <= '0;
            bit_q      <= '0;
            last_bit_q <= '0;
            shift_q    <= '0;
            par_mode_q <= PAR_NONE;
            stop_q     <= STOP_1;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            rdy_en_q   <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            last_bit_q <= last_bit_d;
            shift_q    <= shift_d;
            par_mode_q <= par_mode_d;
            stop_q     <= stop_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
            rdy_en_q   <= 1'b1;
        end
    end

    // The line is registered from the current state, so it trails state entry by one clock.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_IDLE:   tx_d = !tx_break_i;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_bit_q;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        din_ready      = (state_q == ST_IDLE) && !tx_break_i && rdy_en_q;
        busy_o         = (state_q != ST_IDLE);
        tx_done_tick_o = (state_q == ST_STOP) && stop_end;
    end

    assign in_if.din_ready = din_ready;
    assign tx_o            = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - randomized self-checking bench for uart_tx_cfg against a tick-level frame model
module tb_uart_tx_cfg;
    localparam int DBIT_MAX = 9;
    localparam int OS       = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic [3:0] cfg_dbits;
    logic [1:0] cfg_parity;
    logic [1:0] cfg_stop;
    logic       tx_break;
    logic       busy;
    logic       done;
    logic       tx;

    int checks = 0;
    int passed = 0;
    int tick_ph = 0;

    bit exp_tx[$];
    int exp_done[$];

    uart_tx_cfg_if #(.DBIT_MAX(DBIT_MAX)) u_if ();

    uart_tx_cfg #(.DBIT_MAX(DBIT_MAX), .OVERSAMPLE(OS)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_if          (u_if.slave),
        .s_tick_i       (s_tick),
        .cfg_dbits_i    (cfg_dbits),
        .cfg_parity_i   (cfg_parity),
        .cfg_stop_i     (cfg_stop),
        .tx_break_i     (tx_break),
        .busy_o         (busy),
        .tx_done_tick_o (done),
        .tx_o           (tx)
    );

    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_ph = (tick_ph + 1) % 4;
            s_tick  = (tick_ph == 0);
        end
    end

    // Expected line level for every s_tick of a frame, straight from the frame format.
    function automatic void model_frame(input logic [8:0] d, input logic [3:0] nb,
                                        input logic [1:0] par, input logic [1:0] stp);
        int n;
        int nstop;
        bit p;
        n = (nb >= 5 && nb <= DBIT_MAX) ? int'(nb) : DBIT_MAX;
        p = 1'b0;
        for (int k = 0; k < OS; k++) exp_tx.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            p = p ^ d[i];
            for (int k = 0; k < OS; k++) exp_tx.push_back(d[i]);
        end
        if (par == 2'd1 || par == 2'd2) begin
            for (int k = 0; k < OS; k++) exp_tx.push_back(p ^ (par == 2'd2));
        end
        nstop = (stp == 2'd1) ? (3 * OS) / 2 : (stp == 2'd2) ? 2 * OS : OS;
        for (int k = 0; k < nstop; k++) exp_tx.push_back(1'b1);
        exp_done.push_back(exp_tx.size() - 1);
    endfunction

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8 && !ok; k++) begin
            @(negedge clk);
            if (s_tick) ok = 1'b1;
        end
    endtask

    task automatic start_word(input logic [8:0] d, input logic [3:0] nb,
                              input logic [1:0] par, input logic [1:0] stp);
        bit ok;
        wait_tick(ok);
        u_if.din       = d;
        cfg_dbits      = nb;
        cfg_parity     = par;
        cfg_stop       = stp;
        u_if.din_valid = 1'b1;
        checks++;
        if (!ok || u_if.din_ready !== 1'b1)
            $display("FAIL ready_idle: din_ready=%b tick_seen=%b required din_ready=1", u_if.din_ready, ok);
        else
            passed++;
        model_frame(d, nb, par, stp);
        @(negedge clk);
        u_if.din   = 9'($urandom);
        cfg_dbits  = 4'($urandom);
        cfg_parity = 2'($urandom);
        cfg_stop   = 2'($urandom);
    endtask

    task automatic check_stream(input string name);
        int tx_err = 0, done_err = 0, busy_err = 0, first_bad = -1, nd = 0;
        bit got_tx = 1'b0, want_tx = 1'b0, ok, exp_d, timeout = 1'b0;
        for (int j = 0; j < exp_tx.size(); j++) begin
            wait_tick(ok);
            if (!ok) begin
                timeout = 1'b1;
                break;
            end
            if (tx !== exp_tx[j]) begin
                if (first_bad < 0) begin
                    first_bad = j; got_tx = tx; want_tx = exp_tx[j];
                end
                tx_err++;
            end
            exp_d = (nd < exp_done.size()) && (exp_done[nd] == j);
            if (done !== exp_d) done_err++;
            if (busy !== 1'b1) busy_err++;
            if (exp_d) begin
                nd++;
                if (nd < exp_done.size()) begin
                    @(negedge clk);
                    checks++;
                    if (u_if.din_ready !== 1'b1)
                        $display("FAIL %s_b2b_ready: din_ready=%b required 1", name, u_if.din_ready);
                    else
                        passed++;
                    @(negedge clk);
                    u_if.din_valid = 1'b0;
                end
            end
        end
        checks++;
        if (timeout || tx_err != 0)
            $display("FAIL %s_tx: %0d tick errors timeout=%b first at tick %0d got %b required %b",
                     name, tx_err, timeout, first_bad, got_tx, want_tx);
        else
            passed++;
        checks++;
        if (done_err != 0) $display("FAIL %s_done: %0d misplaced done ticks, required 0", name, done_err);
        else passed++;
        checks++;
        if (busy_err != 0) $display("FAIL %s_busy: low on %0d frame ticks, required 0", name, busy_err);
        else passed++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL %s_end: busy=%b done=%b required 0 0", name, busy, done);
        else
            passed++;
        exp_tx.delete();
        exp_done.delete();
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        u_if.din       = '0;
        u_if.din_valid = 1'b0;
        cfg_dbits      = 4'd8;
        cfg_parity     = 2'd0;
        cfg_stop       = 2'd0;
        tx_break       = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || u_if.din_ready !== 1'b0)
            $display("FAIL reset_state: tx=%b busy=%b done=%b ready=%b required 1 0 0 0",
                     tx, busy, done, u_if.din_ready);
        else
            passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (u_if.din_ready !== 1'b1 || tx !== 1'b1)
            $display("FAIL reset_release: ready=%b tx=%b required 1 1", u_if.din_ready, tx);
        else
            passed++;
    endtask

    task automatic test_single(input string name, input logic [8:0] d, input logic [3:0] nb,
                               input logic [1:0] par, input logic [1:0] stp);
        start_word(d, nb, par, stp);
        u_if.din_valid = 1'b0;
        check_stream(name);
    endtask

    task automatic test_directed();
        test_single("8n1_55", 9'h055, 4'd8, 2'd0, 2'd0);
        test_single("7e1_41", 9'h041, 4'd7, 2'd1, 2'd0);
        test_single("7o2_41", 9'h041, 4'd7, 2'd2, 2'd2);
        test_single("5n15_1f", 9'h01F, 4'd5, 2'd0, 2'd1);
        test_single("dbits12", 9'h1A5, 4'd12, 2'd1, 2'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            test_single($sformatf("rand%0d", i), 9'($urandom), 4'($urandom_range(4, 15)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        start_word(9'h0A3, 4'd8, 2'd0, 2'd0);
        u_if.din   = 9'h12D;
        cfg_dbits  = 4'd6;
        cfg_parity = 2'd2;
        cfg_stop   = 2'd2;
        model_frame(9'h12D, 4'd6, 2'd2, 2'd2);
        check_stream("b2b");
    endtask

    task automatic test_break();
        @(negedge clk);
        tx_break       = 1'b1;
        u_if.din_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b0 || u_if.din_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL break_idle: tx=%b ready=%b busy=%b required 0 0 0", tx, u_if.din_ready, busy);
        else
            passed++;
        u_if.din_valid = 1'b0;
        tx_break       = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || u_if.din_ready !== 1'b1)
            $display("FAIL break_release: tx=%b ready=%b required 1 1", tx, u_if.din_ready);
        else
            passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int done_seen = 0;
        start_word(9'h000, 4'd8, 2'd0, 2'd0);
        u_if.din_valid = 1'b0;
        for (int k = 0; k < OS + 40; k++) wait_tick(ok);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || u_if.din_ready !== 1'b0)
            $display("FAIL reset_mid: tx=%b busy=%b ready=%b required 1 0 0", tx, busy, u_if.din_ready);
        else
            passed++;
        exp_tx.delete();
        exp_done.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) $display("FAIL reset_abort: %0d cycles with done/busy/tx wrong, required 0", done_seen);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_break();
        test_reset_mid();
        test_single("after_reset", 9'h0C6, 4'd8, 2'd1, 2'd2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
